// File: rtl/aes_round_sequencer.sv
// rtl/aes_round_sequencer.sv - AES-128/192/256 encrypt/decrypt round sequencer
// Drives the state-matrix muxes and key-expansion handshake for one block at a time.
module aes_round_sequencer #(
  parameter int KEY_BITS = 128,
  parameter int SLICES   = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start_write_n,
  input  logic       start_read_n,
  input  logic       mode_decrypt,
  input  logic       key_expand_done,
  input  logic       abort,
  output logic       done,
  output logic       busy,
  output logic [5:0] dbg_state,
  output logic [3:0] dbg_round,
  output logic [3:0] matrix_in_sel,
  output logic       op_inverse,
  output logic       matrix_write_enable,
  output logic       key_write_enable,
  output logic       key_start,
  output logic [3:0] round_key_idx,
  output logic       input_mat_row_col,
  output logic [1:0] input_mat_idx,
  output logic       output_mat_row_col,
  output logic [1:0] output_mat_idx
);

  localparam int NR = (KEY_BITS == 256) ? 14 : (KEY_BITS == 192) ? 12 : 10;
  localparam int NK = KEY_BITS / 32;
  localparam logic [3:0] NR_L     = 4'(NR);
  localparam logic [2:0] NK_LAST  = 3'(NK - 1);
  // Each op spans SLICES cycles; the slice index advances by 4/SLICES (0 when SLICES=1).
  localparam logic [1:0] SLC_LAST = 2'(SLICES - 1);
  localparam logic [1:0] IDX_STEP = 2'(4 / SLICES);

  localparam logic [3:0] SEL_LOAD  = 4'd0;
  localparam logic [3:0] SEL_SUB   = 4'd1;
  localparam logic [3:0] SEL_SHIFT = 4'd2;
  localparam logic [3:0] SEL_MIX   = 4'd3;
  localparam logic [3:0] SEL_ARK   = 4'd4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PTEXT = 3'd1,
    S_KEY   = 3'd2,
    S_WAIT  = 3'd3,
    S_OP    = 3'd4,
    S_DONE  = 3'd5,
    S_CTEXT = 3'd6
  } state_t;

  state_t     state, nxt_state;
  logic [2:0] cnt, nxt_cnt;
  logic [3:0] round, nxt_round;
  logic [1:0] opp, nxt_opp;
  logic [1:0] slc, nxt_slc;
  logic       mode, nxt_mode;
  logic       op_last;

  logic [3:0] op_sel, op_rk;
  logic [3:0] o_sel, o_rk;
  logic       o_mwe, o_kwe, o_kst, o_irc, o_orc;
  logic [1:0] o_iidx, o_oidx;

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_round = round;
    nxt_opp   = opp;
    nxt_slc   = slc;
    nxt_mode  = mode;
    op_last   = (round == NR_L) ? (opp == 2'd2) : (opp == 2'd3);
    if (abort) begin
      nxt_state = S_IDLE;
      nxt_cnt   = 3'd0;
      nxt_round = 4'd0;
      nxt_opp   = 2'd0;
      nxt_slc   = 2'd0;
      nxt_mode  = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!start_write_n) begin
            nxt_state = S_PTEXT;
            nxt_mode  = mode_decrypt;
            nxt_cnt   = 3'd0;
          end
        end
        S_PTEXT: begin
          if (cnt == 3'd3) begin
            nxt_state = S_KEY;
            nxt_cnt   = 3'd0;
          end else begin
            nxt_cnt = cnt + 3'd1;
          end
        end
        S_KEY: begin
          if (cnt == NK_LAST) begin
            nxt_state = S_WAIT;
            nxt_cnt   = 3'd0;
          end else begin
            nxt_cnt = cnt + 3'd1;
          end
        end
        S_WAIT: begin
          if (key_expand_done) begin
            nxt_state = S_OP;
            nxt_round = 4'd0;
            nxt_opp   = 2'd0;
            nxt_slc   = 2'd0;
          end
        end
        S_OP: begin
          if (slc != SLC_LAST) begin
            nxt_slc = slc + 2'd1;
          end else begin
            nxt_slc = 2'd0;
            // Round 0 holds only the initial AddRoundKey.
            if (round == 4'd0) begin
              nxt_round = 4'd1;
              nxt_opp   = 2'd0;
            end else if (!op_last) begin
              nxt_opp = opp + 2'd1;
            end else if (round == NR_L) begin
              nxt_state = S_DONE;
            end else begin
              nxt_round = round + 4'd1;
              nxt_opp   = 2'd0;
            end
          end
        end
        S_DONE: begin
          if (!start_read_n) begin
            nxt_state = S_CTEXT;
            nxt_cnt   = 3'd0;
          end
        end
        S_CTEXT: begin
          if (cnt == 3'd3) begin
            nxt_state = S_IDLE;
            nxt_cnt   = 3'd0;
            nxt_round = 4'd0;
            nxt_opp   = 2'd0;
            nxt_slc   = 2'd0;
            nxt_mode  = 1'b0;
          end else begin
            nxt_cnt = cnt + 3'd1;
          end
        end
        default: begin
          nxt_state = S_IDLE;
          nxt_cnt   = 3'd0;
          nxt_round = 4'd0;
          nxt_opp   = 2'd0;
          nxt_slc   = 2'd0;
          nxt_mode  = 1'b0;
        end
      endcase
    end
  end

  // Op list position -> transform; decrypt order is ISR, ISB, ARK, IMC.
  always_comb begin
    op_sel = SEL_ARK;
    op_rk  = 4'd0;
    if (nxt_round == 4'd0) begin
      op_sel = SEL_ARK;
      op_rk  = nxt_mode ? NR_L : 4'd0;
    end else if (!nxt_mode) begin
      case (nxt_opp)
        2'd0: op_sel = SEL_SUB;
        2'd1: op_sel = SEL_SHIFT;
        2'd2: begin
          if (nxt_round == NR_L) begin
            op_sel = SEL_ARK;
            op_rk  = nxt_round;
          end else begin
            op_sel = SEL_MIX;
          end
        end
        default: begin
          op_sel = SEL_ARK;
          op_rk  = nxt_round;
        end
      endcase
    end else begin
      case (nxt_opp)
        2'd0: op_sel = SEL_SHIFT;
        2'd1: op_sel = SEL_SUB;
        2'd2: begin
          op_sel = SEL_ARK;
          op_rk  = NR_L - nxt_round;
        end
        default: op_sel = SEL_MIX;
      endcase
    end
  end

  always_comb begin
    o_sel  = SEL_LOAD;
    o_rk   = 4'd0;
    o_mwe  = 1'b0;
    o_kwe  = 1'b0;
    o_kst  = 1'b0;
    o_irc  = 1'b0;
    o_iidx = 2'd0;
    o_orc  = 1'b0;
    o_oidx = 2'd0;
    case (nxt_state)
      S_PTEXT: begin
        o_mwe  = 1'b1;
        o_irc  = 1'b1;
        o_iidx = nxt_cnt[1:0];
      end
      S_KEY: begin
        o_kwe  = 1'b1;
        o_kst  = (nxt_cnt == 3'd0);
        o_irc  = 1'b1;
        o_iidx = nxt_cnt[1:0];
      end
      S_OP: begin
        o_mwe  = 1'b1;
        o_sel  = op_sel;
        o_rk   = op_rk;
        o_irc  = (op_sel == SEL_MIX) || (op_sel == SEL_ARK);
        o_orc  = (op_sel == SEL_MIX) || (op_sel == SEL_ARK);
        o_iidx = nxt_slc * IDX_STEP;
        o_oidx = nxt_slc * IDX_STEP;
      end
      S_CTEXT: begin
        o_orc  = 1'b1;
        o_oidx = nxt_cnt[1:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state               <= S_IDLE;
      cnt                 <= 3'd0;
      round               <= 4'd0;
      opp                 <= 2'd0;
      slc                 <= 2'd0;
      mode                <= 1'b0;
      done                <= 1'b0;
      busy                <= 1'b0;
      dbg_state           <= 6'd0;
      dbg_round           <= 4'd0;
      matrix_in_sel       <= 4'd0;
      op_inverse          <= 1'b0;
      matrix_write_enable <= 1'b0;
      key_write_enable    <= 1'b0;
      key_start           <= 1'b0;
      round_key_idx       <= 4'd0;
      input_mat_row_col   <= 1'b0;
      input_mat_idx       <= 2'd0;
      output_mat_row_col  <= 1'b0;
      output_mat_idx      <= 2'd0;
    end else begin
      state               <= nxt_state;
      cnt                 <= nxt_cnt;
      round               <= nxt_round;
      opp                 <= nxt_opp;
      slc                 <= nxt_slc;
      mode                <= nxt_mode;
      done                <= (nxt_state == S_DONE);
      busy                <= (nxt_state != S_IDLE) && (nxt_state != S_DONE);
      dbg_state           <= {3'b000, nxt_state};
      dbg_round           <= nxt_round;
      matrix_in_sel       <= o_sel;
      op_inverse          <= nxt_mode;
      matrix_write_enable <= o_mwe;
      key_write_enable    <= o_kwe;
      key_start           <= o_kst;
      round_key_idx       <= o_rk;
      input_mat_row_col   <= o_irc;
      input_mat_idx       <= o_iidx;
      output_mat_row_col  <= o_orc;
      output_mat_idx      <= o_oidx;
    end
  end

endmodule
